// File: rtl/bp_pkg.sv
// bp_pkg: shared counter encodings, widths and helpers for the branch predictor
// control stage (bp_update_ctrl) and its saturating-counter sub-module.
package bp_pkg;
    localparam int CWIDTH = 2;
    typedef enum logic [CWIDTH-1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;
    // A branch unseen by the table starts weak in the direction it went,
    // and an unseen branch is guessed not-taken.
    localparam logic [CWIDTH-1:0] MISS_TAKEN     = WT;
    localparam logic [CWIDTH-1:0] MISS_NOT_TAKEN = WNT;
    localparam logic [CWIDTH-1:0] MISS_GUESS     = WNT;
    function automatic logic ctr_taken(input logic [CWIDTH-1:0] c);
        return c[CWIDTH-1];
    endfunction
endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: next value of a 2-bit saturating predictor counter.
// Ports: old_ctr (current counter), hit (old_ctr is valid), taken (outcome),
//        new_ctr (updated counter; miss-initialised when hit is low).
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [CWIDTH-1:0] old_ctr,
    input  logic              hit,
    input  logic              taken,
    output logic [CWIDTH-1:0] new_ctr
);
    always_comb
        new_ctr = !hit ? (taken ? MISS_TAKEN : MISS_NOT_TAKEN) :
                  taken ? (old_ctr == ST ? ST : old_ctr + 1'b1) :
                          (old_ctr == SNT ? SNT : old_ctr - 1'b1);
endmodule

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: predictor control between fetch/execute and the counter table cache.
// Ports: clk, reset_n (async, active-low)
//        guess_valid/guess_pc -> guess_taken/guess_out_valid (one cycle later)
//        check_valid/check_pc/check_taken -> check_mispredict, cache_wa/din/we (U1)
//        cache_reset, cache_ra0/ra1 out; cache_hit0/1, cache_dout0/1 in
// Optional: BP_STATS_EN adds saturating stat_checks / stat_mispredicts outputs.
module bp_update_ctrl #(
    parameter int AWIDTH = 30,
    parameter int CWIDTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              guess_valid,
    input  logic [AWIDTH-1:0] guess_pc,
    output logic              guess_taken,
    output logic              guess_out_valid,
    input  logic              check_valid,
    input  logic [AWIDTH-1:0] check_pc,
    input  logic              check_taken,
    output logic              check_mispredict,
    output logic              cache_reset,
    output logic [AWIDTH-1:0] cache_ra0,
    output logic [AWIDTH-1:0] cache_ra1,
    input  logic              cache_hit0,
    input  logic              cache_hit1,
    input  logic [CWIDTH-1:0] cache_dout0,
    input  logic [CWIDTH-1:0] cache_dout1,
    output logic [AWIDTH-1:0] cache_wa,
    output logic [CWIDTH-1:0] cache_din,
    output logic              cache_we
`ifdef BP_STATS_EN
    ,
    output logic [31:0]       stat_checks,
    output logic [31:0]       stat_mispredicts
`endif
);
    import bp_pkg::*;

    if (CWIDTH != 2) begin : g_cwidth_check
        $error("bp_update_ctrl: CWIDTH must be 2");
    end

    logic [1:0]        rst_sync;
    logic              fwd0;
    logic              fwd1;
    logic              hit_u0;
    logic [CWIDTH-1:0] guess_ctr;
    logic [CWIDTH-1:0] old_ctr;
    logic [CWIDTH-1:0] new_ctr;

    assign cache_ra0   = guess_pc;
    assign cache_ra1   = check_pc;
    assign cache_reset = rst_sync[1];

    // The U1 write lands in the cache only at the end of its cycle, so any read
    // of that address during U1 sees a stale counter; take it from cache_din.
    always_comb begin
        fwd0      = cache_we && cache_wa == guess_pc;
        fwd1      = cache_we && cache_wa == check_pc;
        guess_ctr = fwd0 ? cache_din : cache_hit0 ? cache_dout0 : MISS_GUESS;
        hit_u0    = fwd1 || cache_hit1;
        old_ctr   = fwd1 ? cache_din : cache_dout1;
    end

    bp_sat_counter u_sat (
        .old_ctr (old_ctr),
        .hit     (hit_u0),
        .taken   (check_taken),
        .new_ctr (new_ctr)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            rst_sync         <= 2'b11;
            guess_taken      <= 1'b0;
            guess_out_valid  <= 1'b0;
            check_mispredict <= 1'b0;
            cache_we         <= 1'b0;
            cache_wa         <= '0;
            cache_din        <= '0;
        end else begin
            rst_sync         <= {rst_sync[0], 1'b0};
            guess_out_valid  <= guess_valid;
            if (guess_valid)
                guess_taken <= ctr_taken(guess_ctr);
            cache_we         <= check_valid;
            // A miss reads as weak-NT, so it mispredicts exactly when taken.
            check_mispredict <= check_valid &&
                                (hit_u0 ? ctr_taken(old_ctr) != check_taken : check_taken);
            if (check_valid) begin
                cache_wa  <= check_pc;
                cache_din <= new_ctr;
            end
        end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            stat_checks      <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (cache_we && !(&stat_checks))
                stat_checks <= stat_checks + 1'b1;
            if (check_mispredict && !(&stat_mispredicts))
                stat_mispredicts <= stat_mispredicts + 1'b1;
        end
`endif
endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb_bp_update_ctrl: randomized + directed check of bp_update_ctrl against a predictor table model.
module tb_bp_update_ctrl;
    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          guess_valid = 1'b0;
    logic [AW-1:0] guess_pc = '0;
    logic          guess_taken;
    logic          guess_out_valid;
    logic          check_valid = 1'b0;
    logic [AW-1:0] check_pc = '0;
    logic          check_taken = 1'b0;
    logic          check_mispredict;
    logic          cache_reset;
    logic [AW-1:0] cache_ra0;
    logic [AW-1:0] cache_ra1;
    logic          cache_hit0 = 1'b0;
    logic          cache_hit1 = 1'b0;
    logic [1:0]    cache_dout0 = '0;
    logic [1:0]    cache_dout1 = '0;
    logic [AW-1:0] cache_wa;
    logic [1:0]    cache_din;
    logic          cache_we;
`ifdef BP_STATS_EN
    logic [31:0]   stat_checks;
    logic [31:0]   stat_mispredicts;
`endif

    bp_update_ctrl #(.AWIDTH(AW), .CWIDTH(2)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .guess_valid      (guess_valid),
        .guess_pc         (guess_pc),
        .guess_taken      (guess_taken),
        .guess_out_valid  (guess_out_valid),
        .check_valid      (check_valid),
        .check_pc         (check_pc),
        .check_taken      (check_taken),
        .check_mispredict (check_mispredict),
        .cache_reset      (cache_reset),
        .cache_ra0        (cache_ra0),
        .cache_ra1        (cache_ra1),
        .cache_hit0       (cache_hit0),
        .cache_hit1       (cache_hit1),
        .cache_dout0      (cache_dout0),
        .cache_dout1      (cache_dout1),
        .cache_wa         (cache_wa),
        .cache_din        (cache_din),
        .cache_we         (cache_we)
`ifdef BP_STATS_EN
        ,
        .stat_checks      (stat_checks),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // cmem emulates the table cache (written from the DUT's write port);
    // rtab is the architectural table: every check applied immediately, in order.
    logic [1:0] cmem[logic [AW-1:0]];
    logic [1:0] rtab[logic [AW-1:0]];
    logic [AW-1:0] pool[6];

    logic          e_gt, e_gov, e_mis, e_we;
    logic [AW-1:0] e_wa;
    logic [1:0]    e_din;
    int unsigned   e_sc, e_sm;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("guess_taken", 32'(guess_taken), 32'(e_gt));
        chk("guess_out_valid", 32'(guess_out_valid), 32'(e_gov));
        chk("check_mispredict", 32'(check_mispredict), 32'(e_mis));
        chk("cache_we", 32'(cache_we), 32'(e_we));
        chk("cache_reset", 32'(cache_reset), 32'd0);
        if (e_we) begin
            chk("cache_wa", 32'(cache_wa), 32'(e_wa));
            chk("cache_din", 32'(cache_din), 32'(e_din));
        end
`ifdef BP_STATS_EN
        chk("stat_checks", stat_checks, e_sc);
        chk("stat_mispredicts", stat_mispredicts, e_sm);
`endif
    endtask

    function automatic logic [1:0] lookup(input logic [AW-1:0] pc);
        return rtab.exists(pc) ? rtab[pc] : 2'b01;
    endfunction

    // One clock cycle: called at a negedge, returns at the next negedge after comparing.
    task automatic cycle(input bit gv, input logic [AW-1:0] gpc, input bit cv,
                         input logic [AW-1:0] cpc, input bit ct);
        logic [1:0] o;
        int t;
        guess_valid = gv;
        guess_pc    = gpc;
        check_valid = cv;
        check_pc    = cpc;
        check_taken = ct;
        cache_hit0  = cmem.exists(gpc);
        cache_dout0 = cache_hit0 ? cmem[gpc] : 2'($urandom);
        cache_hit1  = cmem.exists(cpc);
        cache_dout1 = cache_hit1 ? cmem[cpc] : 2'($urandom);
        e_sc += 32'(e_we);
        e_sm += 32'(e_mis);
        o = lookup(gpc);
        if (gv)
            e_gt = o[1];
        e_gov = gv;
        o = lookup(cpc);
        t = int'(o) + (ct ? 1 : -1);
        e_we  = cv;
        e_mis = cv && (o[1] != ct);
        if (cv) begin
            e_wa  = cpc;
            e_din = !rtab.exists(cpc) ? (ct ? 2'b10 : 2'b01) :
                    t > 3 ? 2'd3 : t < 0 ? 2'd0 : 2'(t);
            rtab[cpc] = e_din;
        end
        if (cache_we && !cache_reset)
            cmem[cache_wa] = cache_din;
        #1;
        chk("cache_ra0", 32'(cache_ra0), 32'(gpc));
        chk("cache_ra1", 32'(cache_ra1), 32'(cpc));
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic preload(input logic [AW-1:0] pc, input logic [1:0] v);
        cmem[pc] = v;
        rtab[pc] = v;
    endtask

    task automatic model_reset();
        cmem.delete();
        rtab.delete();
        e_gt = 0; e_gov = 0; e_mis = 0; e_we = 0; e_wa = '0; e_din = '0;
        e_sc = 0; e_sm = 0;
        guess_valid = 0; check_valid = 0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("cache_reset_1st_edge", 32'(cache_reset), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("cache_reset_2nd_edge", 32'(cache_reset), 32'd0);
    endtask

    initial begin
        logic [AW-1:0] p;
        logic [AW-1:0] pc_b2b;
        model_reset();
        pool[0] = 30'h155555FF;
        pool[1] = 30'h0000ABC;
        for (int i = 2; i < 6; i++)
            pool[i] = 30'($urandom);
        repeat (2) @(negedge clk);
        chk("rst_guess_taken", 32'(guess_taken), 32'd0);
        chk("rst_guess_out_valid", 32'(guess_out_valid), 32'd0);
        chk("rst_mispredict", 32'(check_mispredict), 32'd0);
        chk("rst_cache_we", 32'(cache_we), 32'd0);
        chk("rst_cache_wa", 32'(cache_wa), 32'd0);
        chk("rst_cache_din", 32'(cache_din), 32'd0);
        chk("rst_cache_reset", 32'(cache_reset), 32'd1);
        release_reset();

        // miss update
        cycle(0, '0, 1, 30'h155555FF, 1);
        chk("miss_we", 32'(cache_we), 32'd1);
        chk("miss_wa", 32'(cache_wa), 32'h155555FF);
        chk("miss_din", 32'(cache_din), 32'd2);
        chk("miss_mispredict", 32'(check_mispredict), 32'd1);

        // back-to-back same PC from a miss: stale cache, forwarding must win
        pc_b2b = 30'h0000ABC;
        cycle(0, '0, 1, pc_b2b, 1);
        chk("b2b_din0", 32'(cache_din), 32'd2);
        cycle(0, '0, 1, pc_b2b, 1);
        chk("b2b_din1", 32'(cache_din), 32'd3);
        cycle(0, '0, 1, pc_b2b, 0);
        chk("b2b_din2", 32'(cache_din), 32'd2);

        // saturation
        preload(30'h100, 2'b11);
        cycle(0, '0, 1, 30'h100, 1);
        chk("sat_hi_din", 32'(cache_din), 32'd3);
        chk("sat_hi_mispredict", 32'(check_mispredict), 32'd0);
        preload(30'h200, 2'b00);
        cycle(0, '0, 1, 30'h200, 0);
        chk("sat_lo_din", 32'(cache_din), 32'd0);

        // guesses
        preload(30'h300, 2'b10);
        cycle(1, 30'h300, 0, '0, 0);
        chk("guess_hit_10", 32'(guess_taken), 32'd1);
        cycle(1, 30'h3FF0, 0, '0, 0);
        chk("guess_miss", 32'(guess_taken), 32'd0);
        preload(30'h400, 2'b10);
        cycle(0, '0, 1, 30'h400, 0);
        cycle(1, 30'h400, 0, '0, 0);
        chk("guess_fwd_01", 32'(guess_taken), 32'd0);
        preload(30'h500, 2'b01);
        cycle(1, 30'h500, 1, 30'h500, 1);
        chk("guess_same_cycle", 32'(guess_taken), 32'd0);

        // randomized traffic over a small PC pool to force collisions
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                p = pool[$urandom_range(0, 5)];
                if (!(e_we && e_wa == p)) begin
                    cmem.delete(p);
                    rtab.delete(p);
                end
            end
            cycle($urandom_range(0, 3) != 0, pool[$urandom_range(0, 5)],
                  $urandom_range(0, 3) != 0, pool[$urandom_range(0, 5)],
                  1'($urandom));
        end

        // async reset while a write is in U1
        cycle(0, '0, 1, pool[0], 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_cache_we", 32'(cache_we), 32'd0);
        chk("mid_rst_mispredict", 32'(check_mispredict), 32'd0);
        chk("mid_rst_cache_reset", 32'(cache_reset), 32'd1);
`ifdef BP_STATS_EN
        chk("mid_rst_stat_checks", stat_checks, 32'd0);
        chk("mid_rst_stat_mispredicts", stat_mispredicts, 32'd0);
`endif
        model_reset();
        release_reset();

`ifdef BP_STATS_EN
        cycle(0, '0, 1, 30'h777, 1);
        cycle(0, '0, 1, 30'h777, 1);
        cycle(0, '0, 1, 30'h777, 1);
        cycle(0, '0, 1, 30'h777, 0);
        cycle(0, '0, 0, '0, 0);
        chk("stats_checks_4", stat_checks, 32'd4);
        chk("stats_mispredicts_2", stat_mispredicts, 32'd2);
`endif
        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 1) != 0, pool[$urandom_range(0, 5)],
                  $urandom_range(0, 1) != 0, pool[$urandom_range(0, 5)],
                  1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
